// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus. It grants one requester at a
// time, caps each burst at MAX_BURST cycles, and inserts TURN_CYCLES of
// tri-state turnaround after every release.
module uio_bus_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_dout,
  input  logic [8*NREQ-1:0] req_oe,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t          state, state_nxt;
  logic [1:0]      owner, owner_nxt;
  logic [1:0]      ptr, ptr_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [2:0]      tcnt, tcnt_nxt;
  logic [NREQ-1:0] gnt_nxt;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [1:0]        sel;
  logic [NREQ-1:0]   gnt_sel;
  logic              found;
  logic              own_req;
  int unsigned       sel_idx;

  // Round-robin search: rotate req so ptr lands on bit 0, take the lowest set
  // bit, then map the offset back to an absolute index modulo NREQ.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr);
    found   = 1'b0;
    sel_idx = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req_rot[j]) begin
        found   = 1'b1;
        sel_idx = 32'(ptr) + j;
      end
    end
    if (sel_idx >= NREQ) sel_idx = sel_idx - NREQ;
    sel = 2'(sel_idx);
    gnt_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == 2'(i)) gnt_sel[i] = 1'b1;
    end
  end

  // Request level of the current owner.
  always_comb begin
    own_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner == 2'(i)) own_req = req[i];
    end
  end

  // State and grant registers; reset forces the bus idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      tcnt  <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      tcnt  <= tcnt_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Next-state logic for IDLE arbitration, OWN burst tracking and TURN gap.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    gnt_nxt   = gnt;
    unique case (state)
      IDLE: begin
        if (ena && found) begin
          owner_nxt = sel;
          gnt_nxt   = gnt_sel;
          cnt_nxt   = 8'd1;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (!own_req || !ena || cnt == 8'(MAX_BURST)) begin
          gnt_nxt   = '0;
          ptr_nxt   = (owner == 2'(NREQ - 1)) ? 2'd0 : owner + 2'd1;
          tcnt_nxt  = 3'd1;
          state_nxt = TURN;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      TURN: begin
        if (tcnt == 3'(TURN_CYCLES)) state_nxt = IDLE;
        else                         tcnt_nxt  = tcnt + 3'd1;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Pad mux: only the owner's lane reaches the pins, and only while in OWN.
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (state == OWN) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (owner == 2'(i)) begin
          uio_out = req_dout[8*i +: 8];
          uio_oe  = req_oe[8*i +: 8];
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: a 4-requester instance and a
// 3-requester instance for the modulo-3 pointer wrap.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_dout;
  logic [31:0] req_oe;
  logic [3:0]  gnt;
  logic [7:0]  uio_out, uio_oe;
  logic        busy;

  logic [2:0]  req_b = '0;
  logic [23:0] req_dout_b;
  logic [23:0] req_oe_b;
  logic [2:0]  gnt_b;
  logic [7:0]  uio_out_b, uio_oe_b;
  logic        busy_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] lane_dout [4];
  logic [7:0] lane_oe   [4];

  uio_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dout(req_dout),
    .req_oe(req_oe), .gnt(gnt), .uio_out(uio_out), .uio_oe(uio_oe),
    .busy(busy)
  );

  uio_bus_arbiter #(.NREQ(3), .MAX_BURST(8), .TURN_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .req(req_b), .req_dout(req_dout_b),
    .req_oe(req_oe_b), .gnt(gnt_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b),
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    lane_dout = '{8'h11, 8'h22, 8'hA5, 8'h44};
    lane_oe   = '{8'h01, 8'h02, 8'hFF, 8'h08};
    req_dout  = {lane_dout[3], lane_dout[2], lane_dout[1], lane_dout[0]};
    req_oe    = {lane_oe[3], lane_oe[2], lane_oe[1], lane_oe[0]};
    req_dout_b = {8'hC3, 8'hB2, 8'hA1};
    req_oe_b   = {8'h0F, 8'hF0, 8'h3C};

    // Reset state while rst is held, before any clock edge.
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_oe", 32'(uio_oe), 32'h0);
    chk("rst_out", 32'(uio_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single request on lane 2: gnt for 4 cycles, last one with req low.
    req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_out", 32'(uio_out), 32'hA5);
    chk("single_oe", 32'(uio_oe), 32'hFF);
    chk("single_busy", 32'(busy), 32'h1);
    tick();
    tick();
    chk("single_gnt3", 32'(gnt), 32'h4);
    req_dout[23:16] = 8'h5A;
    #1;
    chk("single_comb_out", 32'(uio_out), 32'h5A);
    req_dout[23:16] = 8'hA5;
    tick();
    chk("single_gnt4", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_turn_oe", 32'(uio_oe), 32'h0);
    chk("single_turn_busy", 32'(busy), 32'h1);
    tick();
    chk("single_idle_oe", 32'(uio_oe), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Burst cap on lane 1: 8 high, 2 low, repeating.
    pulse_rst();
    req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("burst_gnt", 32'(gnt), ((k % 10) < 8) ? 32'h2 : 32'h0);
    end
    req = 4'b0000;

    // Fairness with all four requesting: 0,1,2,3,0.
    pulse_rst();
    req = 4'b1111;
    for (int k = 0; k < 50; k++) begin
      tick();
      if ((k % 10) < 8) begin
        chk("rr_gnt", 32'(gnt), 32'h1 << ((k / 10) % 4));
        chk("rr_out", 32'(uio_out), 32'(lane_dout[(k / 10) % 4]));
        chk("rr_oe", 32'(uio_oe), 32'(lane_oe[(k / 10) % 4]));
      end else begin
        chk("rr_gap_gnt", 32'(gnt), 32'h0);
        chk("rr_gap_oe", 32'(uio_oe), 32'h0);
      end
    end
    req = 4'b0000;

    // Skip idle requesters: 0,3,0,3.
    pulse_rst();
    req = 4'b1001;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("skip_gnt", 32'(gnt), ((k % 10) < 8) ? (((k / 10) % 2 == 1) ? 32'h8 : 32'h1) : 32'h0);
    end
    req = 4'b0000;

    // Modulo-3 wrap: 0,2,0.
    pulse_rst();
    req_b = 3'b101;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("wrap3_gnt", 32'(gnt_b), ((k % 10) < 8) ? (((k / 10) % 2 == 1) ? 32'h4 : 32'h1) : 32'h0);
    end
    req_b = 3'b000;

    // Reset in cycle 4 of a lane-2 burst clears outputs without a clock.
    pulse_rst();
    req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    chk("mid_gnt_pre", 32'(gnt), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_oe", 32'(uio_oe), 32'h0);
    chk("mid_rst_out", 32'(uio_out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    req = 4'b1100;
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h4);

    // Dropping ena mid-burst releases after the next edge, then TURN.
    tick();
    ena = 1'b0;
    #1;
    chk("ena_hold_gnt", 32'(gnt), 32'h4);
    tick();
    chk("ena_rel_gnt", 32'(gnt), 32'h0);
    chk("ena_rel_busy", 32'(busy), 32'h1);
    chk("ena_rel_oe", 32'(uio_oe), 32'h0);
    req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("ena_low_gnt", 32'(gnt), 32'h0);
    end
    chk("ena_low_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Round-robin arbiter that shares the project's 8-bit bidirectional `uio` pad bus among up to four internal requesters. It grants ownership of `uio_out`/`uio_oe` to one requester at a time and caps each ownership burst. It also inserts a tri-state turnaround gap between owners so two drivers never overlap. It sits between the internal function blocks and the top-level `uio_out`/`uio_oe` pins of the TinyTapeout user module.

## Interface

Parameters
- `NREQ`, 4: number of requesters, legal 2..4.
- `MAX_BURST`, 8: maximum consecutive cycles one grant may be held, legal 1..255.
- `TURN_CYCLES`, 1: cycles with `uio_oe`=0 after every release, legal 1..4.

Ports
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ena`  in  1: design enable; low blocks new grants and forces release.
- `req`  in  NREQ: request per requester, level-sensitive; held high to keep ownership.
- `req_dout`  in  8*NREQ: requester i drives bits [8i+7:8i] onto `uio_out`.
- `req_oe`  in  8*NREQ: requester i drives bits [8i+7:8i] onto `uio_oe`.
- `gnt`  out  NREQ: one-hot or zero, registered.
- `uio_out`  out  8: muxed data to pads.
- `uio_oe`  out  8: muxed output enable to pads; 1 = drive.
- `busy`  out  1: high in OWN or TURN.

## Operation

- States: IDLE, OWN, TURN. Registers: `state`, `owner` (2 bits), `ptr` (2 bits), `cnt` (8 bits), `tcnt` (3 bits).
- **IDLE**
  - If `ena`=1 and any `req` is set, select the first set bit searching `ptr`, `ptr+1`, … modulo NREQ.
  - Set `owner`, `gnt[owner]`=1 and `cnt`=1, then go to OWN.
  - Otherwise stay in IDLE.
- **OWN**
  - If `req[owner]`=0, `ena`=0, or `cnt`==MAX_BURST: clear `gnt`, set `ptr`=(`owner`+1) mod NREQ and `tcnt`=1, then go to TURN.
  - Otherwise increment `cnt`.
- **TURN**
  - If `tcnt`==TURN_CYCLES, go to IDLE.
  - Otherwise increment `tcnt`.
  - Requests are ignored in TURN.
- Output mux, combinational from registered state:
  - In OWN: `uio_out`=`req_dout[owner]` and `uio_oe`=`req_oe[owner]`.
  - In IDLE and TURN: `uio_out`=0 and `uio_oe`=0.
- The one-hot `gnt` is never multi-hot. Exactly one `gnt` bit is set if and only if state is OWN.
- Requester indices ≥ NREQ do not exist. The `ptr` wrap uses modulo NREQ, e.g. NREQ=3 wraps 2→0.
- Reset (`rst`=1, any state, including mid-burst):
  - Immediately: `gnt`=0, `uio_out`=0, `uio_oe`=0, `busy`=0.
  - `state`=IDLE, `ptr`=0, `cnt`=0, `tcnt`=0.
  - The first grant after reset release favours requester 0.

## Timing

- Grant latency: a `req` sampled high at edge N in IDLE gives `gnt` high after edge N (1 cycle).
- Release latency: `req[owner]` sampled low at edge N drops `gnt` after edge N. `gnt` is therefore high for exactly one cycle during which `req` is already low.
- Burst cap: with `req` held, `gnt` is high for exactly MAX_BURST consecutive cycles.
- Gap between consecutive grants is always TURN_CYCLES+1 cycles, with `uio_oe`=0 throughout:
  - TURN_CYCLES cycles in TURN;
  - 1 cycle in IDLE for arbitration.
- `uio_out`/`uio_oe` follow `gnt` with zero added latency (same cycle).
- Requester data changes propagate combinationally while it owns the bus.
- Simultaneous conditions:
  - `req` drop together with `cnt`==MAX_BURST: single release, no difference.
  - `ena` falling together with a request in IDLE: no grant.
- Deasserting `rst` asynchronously with respect to `clk` is allowed. The first state change is on the first rising edge with `rst`=0.

## Test plan

- **Single request:** `req`=4'b0100 held 3 cycles then dropped, `req_dout[2]`=8'hA5, `req_oe[2]`=8'hFF -> `gnt`=4'b0100 for 4 cycles, `uio_out`=8'hA5 and `uio_oe`=8'hFF only during those cycles, then 2 cycles of `uio_oe`=0 before IDLE.
- **Burst cap (MAX_BURST=8, TURN_CYCLES=1):** `req[1]` held continuously -> `gnt[1]` high 8 cycles, low 2 cycles, high 8 again, repeating.
- **Round-robin fairness:** `req`=4'b1111 held -> grant order 0,1,2,3,0 with each burst 8 cycles and 2-cycle gaps. `gnt` is never multi-hot.
- **Skip and wrap:** `req`=4'b1001 held -> grant order 0,3,0,3. Then NREQ=3 with `req`=3'b101 -> order 0,2,0.
- **Reset mid-burst:** assert `rst` in cycle 4 of a `gnt[2]` burst -> `gnt`, `uio_oe` and `busy` are 0 in the same cycle without waiting for a clock. After release with `req`=4'b1100, the first grant goes to requester 2 (`ptr`=0 search).
- **Enable gating:** drop `ena` mid-burst -> `gnt` clears after the next edge and TURN follows. With `ena`=0 and `req`=4'b1111, `gnt` stays 0 indefinitely.
